// File: rtl/fp_cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_cpu_pkg
// Brief    : Shared FP CPU pipeline types and constants (PC width, bubble word,
//            IF/ID pipeline record).
// Revision : 1.0
// ============================================================================
package fp_cpu_pkg;

    localparam int          PC_WIDTH  = 8;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0]         instr;
        logic [PC_WIDTH-1:0] pc;
        logic                valid;
    } if_id_t;

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_fp_if.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_fp_if
// Brief    : Control, instruction-memory and IF/ID signals of the fetch stage.
// Revision : 1.0
// ============================================================================
interface instruction_fetch_fp_if;
    import fp_cpu_pkg::*;

    logic                halt;
    logic                stall;
    logic                redirect_valid;
    logic [PC_WIDTH-1:0] redirect_target;
    logic                imem_rd_en;
    logic [PC_WIDTH-1:0] imem_addr;
    logic [31:0]         imem_rdata;
    logic [31:0]         instruction;
    logic [PC_WIDTH-1:0] instruction_pc;
    logic [PC_WIDTH-1:0] pc_plus4;
    logic                instruction_valid;

    modport master (
        input  halt, stall, redirect_valid, redirect_target, imem_rdata,
        output imem_rd_en, imem_addr, instruction, instruction_pc, pc_plus4,
               instruction_valid
    );

    modport slave (
        output halt, stall, redirect_valid, redirect_target, imem_rdata,
        input  imem_rd_en, imem_addr, instruction, instruction_pc, pc_plus4,
               instruction_valid
    );

endinterface
`default_nettype wire

// File: rtl/fetch_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_skid_buffer
// Brief    : One-entry IF/ID holding buffer with load, drain and flush.
// Revision : 1.0
// ============================================================================
module fetch_skid_buffer
    import fp_cpu_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   reset,
    input  wire logic   load,
    input  wire logic   drain,
    input  wire logic   flush,
    input  wire if_id_t d,
    output if_id_t      q
);

    if_id_t r_entry;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_entry <= '0;
        end else if (load) begin
            r_entry <= d;
        end else if (drain) begin
            r_entry.valid <= 1'b0;
        end
    end

    assign q = r_entry;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_fp.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_fp
// Brief    : Fetch stage: PC, 1-cycle imem request tracking, skid buffer and
//            IF/ID register with stall / redirect / halt handling.
// Revision : 1.0
// ============================================================================
module instruction_fetch_fp #(
    parameter int                  PC_WIDTH  = fp_cpu_pkg::PC_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
    parameter logic [31:0]         NOP_INSTR = fp_cpu_pkg::NOP_INSTR
) (
    input  wire logic               clk,
    input  wire logic               reset,
    instruction_fetch_fp_if.master  fetch_if
);

    typedef fp_cpu_pkg::if_id_t if_id_t;

    localparam if_id_t c_bubble = '{instr: NOP_INSTR, pc: '0, valid: 1'b0};

    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] r_req_pc;
    logic                r_inflight;
    if_id_t              r_if_id;

    logic                w_issue;
    logic                w_skid_load;
    logic                w_skid_drain;
    logic                w_skid_flush;
    if_id_t              w_skid_q;
    if_id_t              w_fetched;
    if_id_t              w_if_id_next;

    // Under stall a new request is only allowed when nothing is pending, so
    // the returning word always finds an empty skid.
    assign w_issue = !reset && !fetch_if.halt && !fetch_if.redirect_valid &&
                     (!fetch_if.stall || (!r_inflight && !w_skid_q.valid));

    assign w_fetched = '{instr: fetch_if.imem_rdata, pc: r_req_pc, valid: 1'b1};

    // Halt outranks redirect, so a pending word is parked even if redirect is high.
    assign w_skid_load  = !reset && r_inflight &&
                          (fetch_if.halt || (!fetch_if.redirect_valid && fetch_if.stall));
    assign w_skid_flush = !fetch_if.halt && fetch_if.redirect_valid;
    assign w_skid_drain = !fetch_if.halt && !fetch_if.redirect_valid && !fetch_if.stall;

    fetch_skid_buffer u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (w_skid_load),
        .drain (w_skid_drain),
        .flush (w_skid_flush),
        .d     (w_fetched),
        .q     (w_skid_q)
    );

    always_comb begin
        w_if_id_next = r_if_id;
        if (!fetch_if.halt) begin
            if (fetch_if.redirect_valid) begin
                w_if_id_next = c_bubble;
            end else if (!fetch_if.stall) begin
                if (w_skid_q.valid) begin
                    w_if_id_next = w_skid_q;
                end else if (r_inflight) begin
                    w_if_id_next = w_fetched;
                end else begin
                    w_if_id_next = c_bubble;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_req_pc   <= RESET_PC;
            r_inflight <= 1'b0;
            r_if_id    <= c_bubble;
        end else begin
            r_if_id    <= w_if_id_next;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_pc     <= r_pc + PC_WIDTH'(4);
                r_req_pc <= r_pc;
            end else if (!fetch_if.halt && fetch_if.redirect_valid) begin
                r_pc <= {fetch_if.redirect_target[PC_WIDTH-1:2], 2'b00};
            end
        end
    end

    assign fetch_if.imem_rd_en        = w_issue;
    assign fetch_if.imem_addr         = r_pc;
    assign fetch_if.instruction       = r_if_id.instr;
    assign fetch_if.instruction_pc    = r_if_id.pc;
    assign fetch_if.instruction_valid = r_if_id.valid;
    assign fetch_if.pc_plus4          = r_if_id.pc + PC_WIDTH'(4);

endmodule
`default_nettype wire

// File: doc/instruction_fetch_fp.md
# instruction_fetch_fp

Instruction fetch stage of the FP CPU pipeline. It sits directly upstream of the instruction decode stage. It owns the program counter and drives a synchronous, 1-cycle-latency instruction memory. It presents a registered IF/ID word (instruction, its PC, valid, return address) to decode, and honours decode stall, execute-stage redirect (branch/jump) and global halt without dropping or duplicating instructions.

## Interface
Parameters:
- PC_WIDTH, 8: width of the byte PC; matches the 8-bit return address consumed by decode.
- RESET_PC, 8'h00: first fetch address after reset.
- NOP_INSTR, 32'h00000013: bubble word (`addi x0,x0,0`) driven when the output is invalid.

Ports:
- clk, input, 1: single clock; all state updates on posedge.
- reset, input, 1: synchronous, active-high reset.
- halt, input, 1: global freeze; same signal that freezes decode.
- stall, input, 1: decode cannot accept a new word this cycle (load-use or FP multi-cycle hazard).
- redirect_valid, input, 1: EX resolved a taken branch or jump.
- redirect_target, input, PC_WIDTH: new fetch address; bits [1:0] are ignored and treated as 0.
- imem_rd_en, output, 1: memory read request; combinational.
- imem_addr, output, PC_WIDTH: read address, always equal to the PC register.
- imem_rdata, input, 32: data for the address requested in the previous cycle.
- instruction, output, 32: IF/ID instruction word to decode.
- instruction_pc, output, PC_WIDTH: address of `instruction`.
- pc_plus4, output, PC_WIDTH: `instruction_pc + 4`, modulo 2^PC_WIDTH; used as the JAL return address.
- instruction_valid, output, 1: IF/ID word is a real instruction.

## Operation
- State:
  - PC register.
  - `inflight` bit: a request was issued last cycle and is not squashed.
  - 1-entry skid buffer {instr, pc, valid}.
  - IF/ID register.
- Issue rule: `imem_rd_en = !reset && !halt && !redirect_valid && (!stall || (!inflight && !skid_valid))`.
  - When a request issues: the PC advances by 4 and wraps 0xFC→0x00; `inflight` is set to 1 for the next cycle.
  - When no request issues: `inflight` is cleared for the next cycle.
- Return path: when `inflight` is 1, `imem_rdata` is paired with the PC that was issued.
- IF/ID load, when `!stall && !halt`, in priority order:
  1. Skid entry, if valid (skid then empties).
  2. The returning inflight word.
  3. Otherwise NOP_INSTR with valid = 0.
- When `stall` or `halt` holds IF/ID, a returning inflight word is written to the skid.
- Invariant: the skid is never written while valid. `inflight && skid_valid` never holds. Verification asserts both.
- Priority per cycle is reset > halt > redirect > stall > normal.
  - Reset:
    - PC = RESET_PC; `inflight` = 0; skid invalid.
    - IF/ID = {NOP_INSTR, pc 0, valid 0}, so `pc_plus4` = 0x04.
    - `imem_rd_en` = 0.
  - Halt:
    - No issue; PC, IF/ID and skid are held.
    - A pending inflight word goes to the skid.
    - A `redirect_valid` seen during halt is ignored.
  - Redirect:
    - PC = redirect_target; IF/ID = NOP with valid 0; skid invalidated.
    - The inflight word is squashed and its `imem_rdata` is ignored next cycle.
    - No issue this cycle; redirect overrides `stall`.
- Reset asserted mid-stall or mid-redirect gives exactly the reset state on the next edge.

## Timing
- Fetch latency: address issued in cycle N, word visible at `instruction` in cycle N+2.
  - Example: the first word after reset deassertion is valid 2 cycles later.
- Sustained throughput: 1 instruction per cycle with no stall.
- Stall release: the skid word appears the cycle after `stall` falls, and the next word follows in the cycle after that, with no bubble between them.
- Redirect penalty: redirect seen in cycle N; target issued in cycle N+1; target instruction valid in cycle N+3.
  - `instruction_valid` = 0 in cycles N+1 and N+2.
- `pc_plus4` is combinational from `instruction_pc` and has zero latency.

## Structure
- Shared package `fp_cpu_pkg`:
  - PC_WIDTH.
  - NOP_INSTR.
  - `typedef struct packed { logic [31:0] instr; logic [PC_WIDTH-1:0] pc; logic valid; } if_id_t`, used by fetch, decode and the hazard unit.
- Sub-module `fetch_skid_buffer`: a 1-entry buffer of type `if_id_t` with load/drain/flush.
- PC, `inflight` and the issue logic stay in the top module.

## Test plan
- Reset then free run, with imem[0x00]=0x00500093, [0x04]=0x00A00113, [0x08]=0x002081B3 → from cycle 2 the outputs are these words at pc 0x00/0x04/0x08, valid=1, pc_plus4 0x04/0x08/0x0C.
- Stall held 3 cycles while instr@0x04 is at the output → output held; @0x08 captured in the skid; `imem_rd_en` low after the first stall cycle; after release the outputs are @0x08 then @0x0C, with none lost or duplicated.
- `redirect_valid`=1 with target 0x40 in the same cycle as `stall`=1 → next cycle valid=0/NOP and addr=0x40 issued; squashed @old+4 never appears; @0x40 valid 3 cycles after redirect.
- RESET_PC=0xF8 → fetch order 0xF8, 0xFC, 0x00; `pc_plus4` for 0xFC = 0x00.
- Halt asserted for 4 cycles with a request inflight → outputs and PC frozen, `imem_rd_en`=0; after release the inflight word appears next, in order.
- Reset asserted during a stall with the skid full → next cycle valid=0, instruction=0x00000013, skid empty, imem_addr=RESET_PC.
